// File: rtl/alu_exec_stage_if.sv
// Request/result handshake bundle for the ALU execute stage, plus the PSR load/observe path.
// Slave modport is the stage itself; master modport is whoever issues ops and drains results.
interface alu_exec_stage_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_opcode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_c;
    logic             out_err;
    logic [4:0]       psr;
    logic             psr_load;
    logic [4:0]       psr_in;

    modport slave (
        input  in_valid, in_opcode, in_a, in_b, out_ready, psr_load, psr_in,
        output in_ready, out_valid, out_c, out_err, psr
    );

    modport master (
        output in_valid, in_opcode, in_a, in_b, out_ready, psr_load, psr_in,
        input  in_ready, out_valid, out_c, out_err, psr
    );
endinterface

// File: rtl/alu_exec_stage.sv
// Registered 16-bit ALU execute stage with PSR; 1-cycle accept-to-result latency.
// Backpressure: in_ready = !out_valid || out_ready, so a held result stalls new requests.
module alu_exec_stage #(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    alu_exec_stage_if.slave   bus
);
    localparam logic [7:0] OP_ADD    = 8'h01;
    localparam logic [7:0] OP_ADDI   = 8'h11;
    localparam logic [7:0] OP_ADDU   = 8'h02;
    localparam logic [7:0] OP_ADDUI  = 8'h12;
    localparam logic [7:0] OP_ADDCU  = 8'h03;
    localparam logic [7:0] OP_ADDCUI = 8'h13;
    localparam logic [7:0] OP_SUB    = 8'h04;
    localparam logic [7:0] OP_SUBI   = 8'h14;

    // PSR bit positions: {Carry, Flag, Low, Negative, Zero}
    localparam int PSR_C = 4;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_c_q;
    logic             out_err_q;
    logic [4:0]       psr_q;

    logic [WIDTH-1:0] c_d;
    logic             err_d;
    logic [4:0]       psr_d;
    logic             cin;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] diff;
    logic             accept;

    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_c     = out_c_q;
    assign bus.out_err   = out_err_q;
    assign bus.psr       = psr_q;

    assign cin     = ((bus.in_opcode == OP_ADDCU) || (bus.in_opcode == OP_ADDCUI)) ? psr_q[PSR_C] : 1'b0;
    assign sum_ext = {1'b0, bus.in_a} + {1'b0, bus.in_b} + {{WIDTH{1'b0}}, cin};
    assign diff    = bus.in_a - bus.in_b;

    always_comb begin
        c_d   = '0;
        err_d = 1'b0;
        psr_d = 5'b00000;
        unique case (bus.in_opcode)
            OP_ADD, OP_ADDI: begin
                c_d   = sum_ext[WIDTH-1:0];
                psr_d = {1'b0,
                         (bus.in_a[WIDTH-1] == bus.in_b[WIDTH-1]) && (c_d[WIDTH-1] != bus.in_a[WIDTH-1]),
                         1'b0, c_d[WIDTH-1], ~|c_d};
            end
            OP_SUB, OP_SUBI: begin
                c_d   = diff;
                psr_d = {1'b0,
                         (bus.in_a[WIDTH-1] != bus.in_b[WIDTH-1]) && (c_d[WIDTH-1] != bus.in_a[WIDTH-1]),
                         1'b0, c_d[WIDTH-1], ~|c_d};
            end
            OP_ADDU, OP_ADDUI, OP_ADDCU, OP_ADDCUI: begin
                c_d   = sum_ext[WIDTH-1:0];
                psr_d = {sum_ext[WIDTH], 1'b0, 1'b0, 1'b0, ~|c_d};
            end
            default: begin
                err_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_c_q     <= '0;
            out_err_q   <= 1'b0;
            psr_q       <= 5'b00000;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                out_c_q     <= c_d;
                out_err_q   <= err_d;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            // A recognised op's flags take priority over a same-cycle software load.
            if (accept && !err_d) begin
                psr_q <= psr_d;
            end else if (bus.psr_load) begin
                psr_q <= bus.psr_in;
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed cases plus randomized traffic against a
// behavioural model that works from integer arithmetic on the opcode rules.
module tb_alu_exec_stage;
    localparam logic [7:0] OP_ADD    = 8'h01;
    localparam logic [7:0] OP_ADDI   = 8'h11;
    localparam logic [7:0] OP_ADDU   = 8'h02;
    localparam logic [7:0] OP_ADDUI  = 8'h12;
    localparam logic [7:0] OP_ADDCU  = 8'h03;
    localparam logic [7:0] OP_ADDCUI = 8'h13;
    localparam logic [7:0] OP_SUB    = 8'h04;
    localparam logic [7:0] OP_SUBI   = 8'h14;

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    // Model state
    logic        m_vld;
    logic [15:0] m_c;
    logic        m_err;
    logic [4:0]  m_psr;

    alu_exec_stage_if #(.WIDTH(16)) bus ();

    alu_exec_stage #(.WIDTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Status word is {Carry, Flag, Low, Negative, Zero}.
    function automatic void ref_op(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, output logic [15:0] c, output logic err,
                                   output logic [4:0] flags);
        int s;
        int unsigned u;
        c = 16'h0; err = 1'b0; flags = 5'b00000;
        if (op == OP_ADD || op == OP_ADDI || op == OP_SUB || op == OP_SUBI) begin
            if (op == OP_ADD || op == OP_ADDI) s = $signed(a) + $signed(b);
            else                               s = $signed(a) - $signed(b);
            c = s[15:0];
            flags[3] = (s > 32767) || (s < -32768);
            flags[1] = c[15];
            flags[0] = (c == 16'h0);
        end else if (op == OP_ADDU || op == OP_ADDUI || op == OP_ADDCU || op == OP_ADDCUI) begin
            u = a + b;
            if (op == OP_ADDCU || op == OP_ADDCUI) u = u + cin;
            c = u[15:0];
            flags[4] = (u > 65535);
            flags[0] = (c == 16'h0);
        end else begin
            err = 1'b1;
        end
    endfunction

    // Starts and ends just after a falling edge: drive, check in_ready, predict, clock, compare.
    task automatic step(input logic v, input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic ordy, input logic pl, input logic [4:0] pin);
        logic        acc;
        logic [15:0] c;
        logic        e;
        logic [4:0]  f;
        bus.in_valid  = v;
        bus.in_opcode = op;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.out_ready = ordy;
        bus.psr_load  = pl;
        bus.psr_in    = pin;
        #1;
        check_val("in_ready", {31'b0, bus.in_ready}, {31'b0, (!m_vld || ordy)});
        acc = v && (!m_vld || ordy);
        if (acc) begin
            ref_op(op, a, b, m_psr[4], c, e, f);
            m_vld = 1'b1;
            m_c   = c;
            m_err = e;
            if (!e)      m_psr = f;
            else if (pl) m_psr = pin;
        end else begin
            if (ordy) m_vld = 1'b0;
            if (pl)   m_psr = pin;
        end
        @(negedge clk);
        check_val("out_valid", {31'b0, bus.out_valid}, {31'b0, m_vld});
        check_val("psr", {27'b0, bus.psr}, {27'b0, m_psr});
        if (m_vld) begin
            check_val("out_c", {16'b0, bus.out_c}, {16'b0, m_c});
            check_val("out_err", {31'b0, bus.out_err}, {31'b0, m_err});
        end
    endtask

    task automatic model_reset();
        m_vld = 1'b0; m_c = 16'h0; m_err = 1'b0; m_psr = 5'b00000;
    endtask

    logic [7:0] op_tab [8] = '{OP_ADD, OP_ADDI, OP_ADDU, OP_ADDUI, OP_ADDCU, OP_ADDCUI, OP_SUB, OP_SUBI};

    initial begin
        logic [7:0] rop;
        model_reset();
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_opcode = 8'h0;
        bus.in_a      = 16'h0;
        bus.in_b      = 16'h0;
        bus.out_ready = 1'b0;
        bus.psr_load  = 1'b0;
        bus.psr_in    = 5'b0;
        repeat (2) @(negedge clk);
        check_val("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check_val("rst_out_c", {16'b0, bus.out_c}, 32'd0);
        check_val("rst_out_err", {31'b0, bus.out_err}, 32'd0);
        check_val("rst_psr", {27'b0, bus.psr}, 32'd0);
        reset_n = 1'b1;
        #1;
        check_val("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(negedge clk);

        // Signed overflow on add
        step(1, OP_ADD, 16'h7FFF, 16'h0001, 1, 0, 5'b0);
        check_val("add_ovf_c", {16'b0, bus.out_c}, 32'h8000);
        check_val("add_ovf_psr", {27'b0, bus.psr}, 32'b01010);
        check_val("add_ovf_err", {31'b0, bus.out_err}, 32'd0);

        // Subtraction, then zero result
        step(1, OP_SUB, 16'h0F0F, 16'hF0F1, 1, 0, 5'b0);
        check_val("sub1_c", {16'b0, bus.out_c}, 32'h1E1E);
        check_val("sub1_psr", {27'b0, bus.psr}, 32'b00000);
        step(1, OP_SUB, 16'hFFF1, 16'hFFF1, 1, 0, 5'b0);
        check_val("sub2_c", {16'b0, bus.out_c}, 32'h0000);
        check_val("sub2_psr", {27'b0, bus.psr}, 32'b00001);

        // Back-to-back carry chain
        step(1, OP_ADDU, 16'hFFFF, 16'h0001, 1, 0, 5'b0);
        check_val("chain1_c", {16'b0, bus.out_c}, 32'h0000);
        check_val("chain1_psr", {27'b0, bus.psr}, 32'b10001);
        step(1, OP_ADDCU, 16'h0000, 16'h0000, 1, 0, 5'b0);
        check_val("chain2_c", {16'b0, bus.out_c}, 32'h0001);
        check_val("chain2_psr", {27'b0, bus.psr}, 32'b00000);

        // Backpressure: result held, second request waits
        step(1, OP_ADD, 16'd1, 16'd2, 1, 0, 5'b0);
        for (int i = 0; i < 3; i++) begin
            step(1, OP_ADD, 16'd5, 16'd5, 0, 0, 5'b0);
            check_val("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
            check_val("bp_hold_c", {16'b0, bus.out_c}, 32'h0003);
        end
        step(1, OP_ADD, 16'd5, 16'd5, 1, 0, 5'b0);
        check_val("bp_release_c", {16'b0, bus.out_c}, 32'h000A);

        // Unknown opcode leaves PSR alone
        step(0, 8'h00, 16'h0, 16'h0, 1, 1, 5'b10000);
        step(1, 8'hFF, 16'h1234, 16'h5678, 1, 0, 5'b0);
        check_val("unk_err", {31'b0, bus.out_err}, 32'd1);
        check_val("unk_c", {16'b0, bus.out_c}, 32'd0);
        check_val("unk_psr", {27'b0, bus.psr}, 32'b10000);

        // Load vs op conflict, then load alone
        step(1, OP_ADDU, 16'd1, 16'd1, 1, 1, 5'b11111);
        check_val("conflict_psr", {27'b0, bus.psr}, 32'b00000);
        step(0, 8'h00, 16'h0, 16'h0, 1, 1, 5'b11111);
        check_val("load_psr", {27'b0, bus.psr}, 32'b11111);

        // Load together with an unrecognised op takes effect
        step(1, 8'hEE, 16'h0, 16'h0, 1, 1, 5'b00100);
        check_val("unk_load_psr", {27'b0, bus.psr}, 32'b00100);

        // Asynchronous reset mid-stream with a pending result
        step(1, OP_ADDU, 16'hFFFF, 16'h0002, 0, 0, 5'b0);
        #3;
        reset_n = 1'b0;
        #1;
        check_val("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check_val("midrst_psr", {27'b0, bus.psr}, 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        step(1, OP_ADDCU, 16'h0000, 16'h0000, 1, 0, 5'b0);
        check_val("midrst_chain_c", {16'b0, bus.out_c}, 32'h0000);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rop = ($urandom_range(0, 9) == 0) ? 8'($urandom) : op_tab[$urandom_range(0, 7)];
            step($urandom_range(0, 3) != 0, rop, 16'($urandom), 16'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 5'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
